// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding and
// the legal parameter ranges checked when the detector is elaborated.
package seq_pattern_pkg;

  // Detector states. 2'b11 is unused and recovers to ST_FILL.
  typedef enum logic [1:0] {
    ST_FILL  = 2'b00,
    ST_ARMED = 2'b01,
    ST_MATCH = 2'b10
  } state_e;

  // Legal range of the pattern length.
  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

  // Legal range of the match counter width.
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;

endpackage : seq_pattern_pkg

// File: rtl/seq_pattern_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear. It holds at all-ones instead
// of wrapping. Clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step up unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/seq_pattern_fsm.sv
// Serial pattern detector. Accepted bits (In_valid=1) shift into a history
// register and are compared live against Pattern. A complete match puts the
// FSM into MATCH for one cycle (Moore flag Out1) and bumps a saturating
// counter. Overlap selects whether the bits of one match may start the next.
module seq_pattern_fsm
  import seq_pattern_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             In1,
  input  logic             In_valid,
  input  logic [PAT_W-1:0] Pattern,
  input  logic             Overlap,
  input  logic             Clear,
  output logic             Out1,
  output logic [CNT_W-1:0] Match_count,
  output logic [1:0]       State
);

  // Parameter sanity checks at elaboration.
  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_pattern_fsm: PAT_W=%0d outside %0d..%0d", PAT_W, PAT_W_MIN, PAT_W_MAX);
  end
  if ((CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
    $error("seq_pattern_fsm: CNT_W=%0d outside %0d..%0d", CNT_W, CNT_W_MIN, CNT_W_MAX);
  end

  // fcnt only needs to count up to PAT_W.
  localparam int FCNT_W = $clog2(PAT_W + 1);
  localparam logic [FCNT_W-1:0] FCNT_ARM  = FCNT_W'(PAT_W - 1);
  localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(PAT_W);

  // Only the newest PAT_W-1 bits are kept: the oldest bit of the PAT_W-bit
  // history is shifted out on the very edge that would next compare it, so
  // it is never observable.
  logic [PAT_W-2:0]  hist_q;
  logic [PAT_W-2:0]  hist_d;
  logic [FCNT_W-1:0] fcnt_q;
  logic [FCNT_W-1:0] fcnt_d;
  state_e            state_q;
  state_e            state_d;

  logic [PAT_W-1:0]  window;
  logic              hit;
  logic              cnt_inc;

  // Candidate PAT_W-bit window formed by history plus the bit on the wire.
  assign window = {hist_q, In1};
  assign hit    = In_valid && (window == Pattern) && (fcnt_q >= FCNT_ARM);

  // Next history, fill count and state; Clear overrides everything.
  always_comb begin
    hist_d  = hist_q;
    fcnt_d  = fcnt_q;
    state_d = ST_FILL;
    if (Clear) begin
      hist_d  = '0;
      fcnt_d  = '0;
      state_d = ST_FILL;
    end else begin
      if (In_valid) begin
        hist_d = window[PAT_W-2:0];
        if (hit && !Overlap) begin
          fcnt_d = '0;
        end else if (fcnt_q != FCNT_FULL) begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      case (state_q)
        ST_FILL, ST_ARMED, ST_MATCH: begin
          if (hit) begin
            state_d = ST_MATCH;
          end else if (fcnt_d >= FCNT_ARM) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_FILL;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  // State, history and fill-count registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist_q  <= '0;
      fcnt_q  <= '0;
      state_q <= ST_FILL;
    end else begin
      hist_q  <= hist_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
    end
  end

  // The counter steps exactly on edges that enter MATCH (never under Clear).
  assign cnt_inc = (state_d == ST_MATCH);

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (cnt_inc),
    .clr   (Clear),
    .count (Match_count)
  );

  assign Out1  = (state_q == ST_MATCH);
  assign State = state_q;

endmodule : seq_pattern_fsm

// File: tb/tb_seq_pattern_fsm.sv
// Bench for seq_pattern_fsm: two instances (8-bit and 2-bit counters) share
// one stimulus stream. Expected values come from a queue-based model of the
// detection rules; directed scenarios are followed by a randomized run.
module tb_seq_pattern_fsm;

  localparam int PAT_W = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       In1 = 1'b0;
  logic       In_valid = 1'b0;
  logic [3:0] pat = 4'b1011;
  logic       ov = 1'b1;
  logic       Clear = 1'b0;

  logic       out1_a, out1_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [1:0] state_a, state_b;

  int checks = 0;
  int errors = 0;

  // reference model
  bit hist[$];
  int since = 0;
  int exp_st = 0;
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;
  int highs = 0;

  always #5 CLK = ~CLK;

  seq_pattern_fsm #(.PAT_W(PAT_W), .CNT_W(8)) u_dut (
    .CLK(CLK), .RST(RST), .In1(In1), .In_valid(In_valid), .Pattern(pat),
    .Overlap(ov), .Clear(Clear), .Out1(out1_a), .Match_count(cnt_a), .State(state_a)
  );

  seq_pattern_fsm #(.PAT_W(PAT_W), .CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .In1(In1), .In_valid(In_valid), .Pattern(pat),
    .Overlap(ov), .Clear(Clear), .Out1(out1_b), .Match_count(cnt_b), .State(state_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    since = 0;
    exp_st = 0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
  endtask

  // Predict the result of one clock edge from the detection rules.
  task automatic model_edge(input bit v, input bit b, input bit clr);
    bit hit;
    int val;
    if (clr) begin
      model_reset();
    end else begin
      hit = 1'b0;
      if (v) begin
        if (since >= PAT_W - 1) begin
          val = 0;
          for (int i = hist.size() - (PAT_W - 1); i < hist.size(); i++)
            val = val * 2 + int'(hist[i]);
          val = val * 2 + int'(b);
          hit = (val == int'(pat));
        end
        hist.push_back(b);
        if (hist.size() > PAT_W) void'(hist.pop_front());
        if (hit && !ov) since = 0;
        else if (since < PAT_W) since = since + 1;
        if (hit) begin
          if (exp_cnt_a < 255) exp_cnt_a++;
          if (exp_cnt_b < 3) exp_cnt_b++;
        end
      end
      exp_st = hit ? 2 : ((since >= PAT_W - 1) ? 1 : 0);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".state"}, 32'(state_a), 32'(exp_st));
    chk({tag, ".out1"},  32'(out1_a),  32'(exp_st == 2));
    chk({tag, ".cnt"},   32'(cnt_a),   32'(exp_cnt_a));
    chk({tag, ".state2"}, 32'(state_b), 32'(exp_st));
    chk({tag, ".out1_2"}, 32'(out1_b),  32'(exp_st == 2));
    chk({tag, ".cnt2"},  32'(cnt_b),   32'(exp_cnt_b));
  endtask

  task automatic step(input string tag, input bit v, input bit b, input bit clr);
    In_valid = v;
    In1 = b;
    Clear = clr;
    model_edge(v, b, clr);
    @(posedge CLK);
    #1;
    check_outputs(tag);
    if (out1_a) highs++;
  endtask

  task automatic feed(input string tag, input int n, input logic [15:0] bits);
    logic [15:0] t;
    t = bits;
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, t[i], 1'b0);
  endtask

  initial begin
    // power-on reset
    model_reset();
    @(posedge CLK);
    #1;
    check_outputs("por");
    RST = 1'b0;

    // fill sequence and basic hit
    step("fill1", 1'b1, 1'b1, 1'b0);
    chk("fill1_state", 32'(state_a), 32'd0);
    step("fill2", 1'b1, 1'b0, 1'b0);
    chk("fill2_state", 32'(state_a), 32'd0);
    step("fill3", 1'b1, 1'b1, 1'b0);
    chk("fill3_state", 32'(state_a), 32'd1);
    chk("fill3_out1", 32'(out1_a), 32'd0);
    step("hit", 1'b1, 1'b1, 1'b0);
    chk("hit_out1", 32'(out1_a), 32'd1);
    chk("hit_cnt", 32'(cnt_a), 32'd1);

    // asynchronous reset while in MATCH
    #1 RST = 1'b1;
    #1;
    model_reset();
    chk("arst_out1", 32'(out1_a), 32'd0);
    chk("arst_cnt", 32'(cnt_a), 32'd0);
    chk("arst_state", 32'(state_a), 32'd0);
    @(posedge CLK);
    #1;
    check_outputs("arst_hold");
    RST = 1'b0;

    // overlapping detection: 1011011 -> two hits
    highs = 0;
    feed("ovl", 7, 16'b1011011);
    chk("ovl_out1_last", 32'(out1_a), 32'd1);
    chk("ovl_cnt", 32'(cnt_a), 32'd2);
    chk("ovl_highs", 32'(highs), 32'd2);

    // non-overlapping: same stream -> one hit
    step("clr1", 1'b0, 1'b0, 1'b1);
    chk("clr1_cnt", 32'(cnt_a), 32'd0);
    ov = 1'b0;
    highs = 0;
    feed("novl", 7, 16'b1011011);
    chk("novl_cnt", 32'(cnt_a), 32'd1);
    chk("novl_highs", 32'(highs), 32'd1);

    // valid gaps keep the partial match
    step("clr2", 1'b0, 1'b0, 1'b1);
    highs = 0;
    feed("gap_a", 2, 16'b10);
    for (int i = 0; i < 5; i++) step("gap_idle", 1'b0, 1'b1, 1'b0);
    chk("gap_idle_highs", 32'(highs), 32'd0);
    feed("gap_b", 2, 16'b11);
    chk("gap_out1", 32'(out1_a), 32'd1);
    chk("gap_cnt", 32'(cnt_a), 32'd1);

    // saturation with back-to-back matches
    pat = 4'b1111;
    ov = 1'b1;
    step("clr3", 1'b0, 1'b0, 1'b1);
    highs = 0;
    feed("sat", 10, 16'b1111111111);
    chk("sat_highs", 32'(highs), 32'd7);
    chk("sat_cnt2", 32'(cnt_b), 32'd3);
    chk("sat_cnt8", 32'(cnt_a), 32'd7);

    // Clear beats a hit on the same edge
    pat = 4'b1011;
    step("clr4", 1'b0, 1'b0, 1'b1);
    feed("cp_pre", 3, 16'b101);
    step("cp_clr", 1'b1, 1'b1, 1'b1);
    chk("cp_state", 32'(state_a), 32'd0);
    chk("cp_out1", 32'(out1_a), 32'd0);
    chk("cp_cnt", 32'(cnt_a), 32'd0);
    feed("cp_post", 4, 16'b1011);
    chk("cp_post_out1", 32'(out1_a), 32'd1);
    chk("cp_post_cnt", 32'(cnt_a), 32'd1);

    // randomized run
    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 0) begin
        pat = 4'($urandom_range(0, 15));
        ov = 1'($urandom_range(0, 1));
      end
      step("rnd", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 59) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_pattern_fsm

// File: doc/seq_pattern_fsm.md
# seq_pattern_fsm

Parametrised serial pattern-detector state machine, the next generation of the team's fixed three-state detector FSMs. It compares a qualified serial bit stream against a runtime-programmable PAT_W-bit pattern and emits a one-cycle Moore match flag. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits on a serial input path as a standalone monitor; nothing in it is sticky beyond the counter.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, width of the match counter; legal range 1..32.

- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- In1  in  1  serial data bit.
- In_valid  in  1  qualifies In1. A bit is "accepted" on a CLK edge where In_valid=1.
- Pattern  in  PAT_W  target pattern. Pattern[PAT_W-1] is the oldest (first-received) bit.
- Overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- Clear  in  1  synchronous clear of history, state and counter.
- Out1  out  1  match flag; high exactly while state = MATCH.
- Match_count  out  CNT_W  number of matches since reset/Clear, saturating.
- State  out  2  current state encoding, for debug.

## Operation
- History: shift register sr[PAT_W-1:0]. On each accepted bit, sr <= {sr[PAT_W-2:0], In1}.
- Fill counter fcnt counts accepted bits since reset, Clear or a non-overlap match, and saturates at PAT_W.
- Hit: In_valid=1 and {sr[PAT_W-2:0], In1} == Pattern and fcnt >= PAT_W-1.
- States:
  - FILL=2'b00: fewer than PAT_W-1 bits held.
  - ARMED=2'b01: next accepted bit can complete a match.
  - MATCH=2'b10.
- Transitions, evaluated every edge, Clear taking priority:
  - Any state, hit -> MATCH.
  - Otherwise, next fcnt >= PAT_W-1 -> ARMED, else FILL.
  - Without an accepted bit, FILL and ARMED hold. MATCH leaves after one cycle to ARMED or FILL according to fcnt.
- Non-overlap: on a hit, fcnt <= 0 and sr is still updated. A fresh PAT_W bits are needed before the next hit.
- Overlap: on a hit, fcnt is unchanged (stays at PAT_W). Back-to-back MATCH cycles are legal, e.g. Pattern all-ones with continuous ones.
- Out1 = (State == MATCH). It is Moore-decoded from the registered state only, with no combinational path from In1.
- Match_count increments on every edge that enters MATCH from a hit, and saturates at 2^CNT_W-1 (no wrap).
- Clear=1 on an edge forces: sr=0, fcnt=0, State=FILL, Match_count=0. A bit presented in the same cycle is discarded.
- Pattern is compared live and is expected to be held stable. A change takes effect on the next accepted bit; history is retained.
- Unused encoding 2'b11 recovers to FILL on the next edge with Out1=0.

## Timing
- Reset (RST high, asynchronous): State=FILL, sr=0, fcnt=0, Out1=0, Match_count=0. Release is synchronous to CLK and the first accepted bit is on the first edge after release.
- Latency: the bit completing the pattern is accepted on edge N. State=MATCH and Out1=1 during cycle N..N+1; Match_count updates on edge N.
- Out1 width is exactly one cycle per hit. Consecutive hits give consecutive high cycles.
- In_valid gaps do not break a partial match; history persists indefinitely.
- RST asserted mid-MATCH: Out1 drops asynchronously, and the counter value is lost.
- Clear and a hit on the same edge: Clear wins; no MATCH and Match_count=0.

## Structure
- Package seq_pattern_pkg holds:
  - the state typedef and the FILL/ARMED/MATCH encodings;
  - the PAT_W/CNT_W legal-range constants used by elaboration-time assertions.
- One sub-module is natural: sat_counter (parameter W; inputs inc and clr; output count), which implements Match_count.
- History, fcnt and the state register stay in the top module.

## Test plan
- Reset/fill (PAT_W=4, Pattern=4'b1011): assert RST mid-stream -> all outputs 0 immediately. Feed 1,0,1 -> State FILL,FILL,ARMED and Out1=0.
- Basic hit: stream 1,0,1,1 continuous valid -> Out1=1 for exactly the cycle after the 4th bit; Match_count=1.
- Overlap=1, stream 1,0,1,1,0,1,1 -> hits after bits 4 and 7; Match_count=2. Same stream with Overlap=0 -> hit after bit 4 only; Match_count=1.
- In_valid gaps: 1,0,(idle 5 cycles),1,1 -> single hit after the last bit; Out1 stays 0 during idle.
- Saturation (CNT_W=2, Pattern=4'b1111, Overlap=1): 10 continuous ones -> 7 consecutive Out1 cycles; Match_count stops at 3.
- Clear priority: assert Clear on the edge accepting the 4th bit of 1011 -> no MATCH; Match_count=0; State=FILL; the next 1,0,1,1 hits normally.
